decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I/RV64I decode pipeline stage sitting between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and produces a full control word with rd/rs1/rs2, funct fields and a sign-extended immediate. It adds a 2-slot elastic output (output register plus skid register), a load-use interlock and a flush. Unlike the combinational decoder, every opcode class, including JAL, JALR and AUIPC, drives a complete control word.

## Interface
- XLEN, 32: datapath width (32 or 64); immediates sign-extended to XLEN; pc width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held instructions and hazard state.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  decode accepts this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction pc.
- out_valid  out  1  control word valid.
- out_ready  in  1  execute consumes this cycle.
- out_ctrl  out  ctrl_t  op1sel, op2sel, wbsel, memwr, memrd, regwr, isbr, isjal, isjalr, illegal.
- out_rd, out_rs1, out_rs2  out  5 each  register addresses.
- out_funct3  out  3; out_funct7b5  out  1.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  pc of the instruction.

## Operation
- Control encoding:
  - op1sel: 0=rs1, 1=pc, 2=zero.
  - op2sel: 0=rs2, 1=imm.
  - wbsel: 0=alu, 1=mem, 2=pc+4.
- Per opcode class:
  - ALU (0110011): rs1/rs2, regwr.
  - ALUi (0010011): rs1/imm I, regwr.
  - Load: rs1/imm I, memrd, wbsel=1, regwr.
  - Store: rs1/imm S, memwr.
  - Branch: rs1/rs2, imm B, isbr.
  - JAL: pc/imm J, wbsel=2, regwr to rd.
  - JALR: rs1/imm I, wbsel=2, regwr.
  - LUI: zero/imm U, regwr.
  - AUIPC: pc/imm U, regwr.
  - Any other opcode: no-op control word (all enables 0).
- Source use: rs1 is used by ALU, ALUi, load, store, branch and JALR. rs2 is used by ALU, store and branch. LUI, AUIPC and JAL use no source register.
- Load-use interlock: the block tracks the rd of the most recently accepted instruction when that instruction was a load with rd≠0. If the next offered instruction uses that register as a source, in_ready is 0 for exactly one cycle, then the tracking clears.
- Elastic buffer: if out_valid&&!out_ready when a new instruction is accepted, the new instruction goes to the skid register. in_ready = !skid_full && !hazard. Output order is always preserved.
- Flush: clears out_valid, skid_full and hazard tracking at the next edge. The in_valid/in_instr offered in the flush cycle is dropped. in_ready is 0 during flush.

## Timing
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1/cycle with no stall.
- Reset values: out_valid=0, skid_full=0, hazard tracking clear, out_ctrl all 0, out_imm/out_pc/out_rd/out_rs1/out_rs2/out_funct3/out_funct7b5 = 0. in_ready=1 once rst_n deasserts.
- Empty buffer with out_ready=1: a transfer in and a transfer out in the same cycle is legal. The buffer stays 1 deep.
- Full buffer (output and skid both occupied): in_ready=0. When out_ready=1, the skid entry moves to the output register and in_ready returns to 1 the next cycle.
- Flush takes priority over hazard stall and over acceptance in the same cycle.
- Reset asserted mid-stall: all state returns to reset values immediately (asynchronous).

## Configuration
- DECODE_ILLEGAL_TRAP_EN:
  - Defined: an unknown opcode, or funct3 not valid for its class, sets ctrl.illegal=1 with all enables 0, and the instruction still propagates.
  - Undefined: ctrl.illegal is tied to 0 and unknown opcodes decode as no-op.

## Structure
- Package decode_pkg:
  - opcode localparams.
  - op1sel/op2sel/wbsel enums.
  - ctrl_t packed struct.
  - NOP_CTRL constant.
- Sub-module imm_gen, parametrised by XLEN: combinational I/S/B/U/J immediate extraction and sign-extension selected by opcode.
- Top level holds the buffer, handshake and hazard logic.

## Test plan
- addi x5,x0,-1 (0xFFF00293) with out_ready=1 → next cycle out_valid=1, regwr=1, op2sel=1, out_imm=0xFFFFFFFF, out_rd=5.
- lw x6,0(x5) (0x0002A303) then add x7,x6,x6 (0x006303B3) back-to-back → in_ready=0 for exactly one cycle, the add is accepted in the following cycle, and 0x006303B3 is emitted second.
- Stream of 4 instructions with out_ready=0 for 3 cycles → in_ready falls after 2 acceptances, no loss or reordering, all 4 emitted in order after out_ready=1.
- jal x1,+8 (0x008000EF) at pc 0x100 → isjal=1, wbsel=2, regwr=1, out_rd=1, op1sel=1, out_imm=8, out_pc=0x100.
- Buffer full and a hazard pending, then flush for 1 cycle → out_valid=0 and in_ready=1 the cycle after flush, and the next instruction is accepted with no residual stall.
- 0x00000000 → with DECODE_ILLEGAL_TRAP_EN: illegal=1, regwr=0, memwr=0. Without it: illegal=0 and a no-op control word.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg: shared types and helpers for the RV32I/RV64I decode stage.
//   - opcode localparams
//   - op1sel/op2sel/wbsel enums, ctrl_t control word, NOP_CTRL
//   - dec_t: width-independent part of the decoded payload
//   - helpers: base_ctrl, uses_rs1, uses_rs2, legal_insn
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (consumed by decode_stage).
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {OP1_RS1 = 2'd0, OP1_PC = 2'd1, OP1_ZERO = 2'd2} op1sel_e;
    typedef enum logic       {OP2_RS2 = 1'b0, OP2_IMM = 1'b1} op2sel_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wbsel_e;

    typedef struct packed {
        op1sel_e op1sel;
        op2sel_e op2sel;
        wbsel_e  wbsel;
        logic    memwr;
        logic    memrd;
        logic    regwr;
        logic    isbr;
        logic    isjal;
        logic    isjalr;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '0;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [2:0]       funct3;
        logic             funct7b5;
    } dec_t;

    // Control word per opcode class; unknown opcodes give the no-op word.
    function automatic ctrl_t base_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = NOP_CTRL;
        case (opcode)
            OPC_ALU:    c.regwr = 1'b1;
            OPC_ALUI:   begin c.op2sel = OP2_IMM; c.regwr = 1'b1; end
            OPC_LOAD:   begin c.op2sel = OP2_IMM; c.memrd = 1'b1; c.wbsel = WB_MEM; c.regwr = 1'b1; end
            OPC_STORE:  begin c.op2sel = OP2_IMM; c.memwr = 1'b1; end
            OPC_BRANCH: c.isbr = 1'b1;
            OPC_JAL:    begin c.op1sel = OP1_PC; c.op2sel = OP2_IMM; c.wbsel = WB_PC4;
                              c.regwr = 1'b1; c.isjal = 1'b1; end
            OPC_JALR:   begin c.op2sel = OP2_IMM; c.wbsel = WB_PC4; c.regwr = 1'b1; c.isjalr = 1'b1; end
            OPC_LUI:    begin c.op1sel = OP1_ZERO; c.op2sel = OP2_IMM; c.regwr = 1'b1; end
            OPC_AUIPC:  begin c.op1sel = OP1_PC; c.op2sel = OP2_IMM; c.regwr = 1'b1; end
            default:    ;
        endcase
        return c;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OPC_ALU)   || (opcode == OPC_ALUI)   || (opcode == OPC_LOAD) ||
               (opcode == OPC_STORE) || (opcode == OPC_BRANCH) || (opcode == OPC_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_ALU) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

    // Known opcode with a funct3 that exists for its class.
    function automatic logic legal_insn(input logic [6:0] opcode, input logic [2:0] funct3,
                                        input logic rv64);
        case (opcode)
            OPC_ALU, OPC_ALUI, OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
            OPC_LOAD:   return (funct3 != 3'd7) && (rv64 || (funct3 != 3'd3 && funct3 != 3'd6));
            OPC_STORE:  return (funct3 <= 3'd2) || (rv64 && funct3 == 3'd3);
            OPC_BRANCH: return (funct3 != 3'd2) && (funct3 != 3'd3);
            OPC_JALR:   return funct3 == 3'd0;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen: combinational I/S/B/U/J immediate extraction, chosen by opcode and
// sign-extended to XLEN. Opcodes without an immediate produce zero.
//   instr  in  32    instruction word
//   imm    out XLEN  sign-extended immediate
// -----------------------------------------------------------------------------
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OPC_ALUI, OPC_LOAD, OPC_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Signed size cast sign-extends for XLEN=64 and is a pass-through at 32.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage: registered RV32I/RV64I decode stage between fetch and execute.
// Two-entry elastic output (output register + skid register), one-cycle
// load-use interlock, and flush.
//   clk, rst_n          clock, async active-low reset
//   flush               drop held instructions and hazard tracking
//   in_valid/in_ready   fetch handshake; in_instr (32), in_pc (XLEN)
//   out_valid/out_ready execute handshake
//   out_ctrl            ctrl_t control word
//   out_rd/rs1/rs2      register addresses; out_funct3, out_funct7b5
//   out_imm, out_pc     sign-extended immediate and pc (XLEN)
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN flags unknown opcodes and
// invalid funct3 as illegal; otherwise illegal is always 0.
// -----------------------------------------------------------------------------
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output ctrl_t            out_ctrl,
    output logic [REG_W-1:0] out_rd,
    output logic [REG_W-1:0] out_rs1,
    output logic [REG_W-1:0] out_rs2,
    output logic [2:0]       out_funct3,
    output logic             out_funct7b5,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc
);

    logic [6:0]       opcode_c;
    dec_t             dec_c;
    logic [XLEN-1:0]  imm_c;
    dec_t             out_q;
    dec_t             skid_q;
    logic [XLEN-1:0]  skid_imm;
    logic [XLEN-1:0]  skid_pc;
    logic             skid_full;
    logic             track_valid;
    logic [REG_W-1:0] track_rd;
    logic             hazard_c;
    logic             accept_c;
    logic             out_free_c;

    assign opcode_c = in_instr[6:0];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .imm   (imm_c)
    );

    // Field extraction and control word for the offered instruction.
    always_comb begin
        dec_c          = '0;
        dec_c.ctrl     = base_ctrl(opcode_c);
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (!legal_insn(opcode_c, in_instr[14:12], 1'(XLEN == 64))) begin
            dec_c.ctrl         = NOP_CTRL;
            dec_c.ctrl.illegal = 1'b1;
        end
`endif
        dec_c.rd       = in_instr[11:7];
        dec_c.rs1      = in_instr[19:15];
        dec_c.rs2      = in_instr[24:20];
        dec_c.funct3   = in_instr[14:12];
        dec_c.funct7b5 = in_instr[30];
    end

    // Offered instruction reads the rd of the load accepted just before it.
    assign hazard_c = in_valid && track_valid &&
                      ((uses_rs1(opcode_c) && (in_instr[19:15] == track_rd)) ||
                       (uses_rs2(opcode_c) && (in_instr[24:20] == track_rd)));

    assign in_ready   = !flush && !skid_full && !hazard_c;
    assign accept_c   = in_valid && in_ready;
    assign out_free_c = !out_valid || out_ready;

    // Output/skid buffer: skid drains first so order is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            skid_full <= 1'b0;
            skid_q    <= '0;
            skid_imm  <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (out_free_c) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_q     <= skid_q;
                out_imm   <= skid_imm;
                out_pc    <= skid_pc;
                skid_full <= 1'b0;
            end else begin
                out_valid <= accept_c;
                if (accept_c) begin
                    out_q   <= dec_c;
                    out_imm <= imm_c;
                    out_pc  <= in_pc;
                end
            end
        end else if (accept_c) begin
            skid_full <= 1'b1;
            skid_q    <= dec_c;
            skid_imm  <= imm_c;
            skid_pc   <= in_pc;
        end
    end

    // Load-use tracking: a stall cycle consumes the tracked load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            track_valid <= 1'b0;
            track_rd    <= '0;
        end else if (flush || hazard_c) begin
            track_valid <= 1'b0;
        end else if (accept_c) begin
            track_valid <= dec_c.ctrl.memrd && (dec_c.rd != '0);
            track_rd    <= dec_c.rd;
        end
    end

    assign out_ctrl     = out_q.ctrl;
    assign out_rd       = out_q.rd;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_funct3   = out_q.funct3;
    assign out_funct7b5 = out_q.funct7b5;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage: directed self-checking bench for decode_stage (XLEN=32).
// Honours DECODE_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
// -----------------------------------------------------------------------------
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_LW      = 32'h0002A303; // lw   x6,0(x5)
    localparam logic [31:0] I_ADD     = 32'h006303B3; // add  x7,x6,x6
    localparam logic [31:0] I_ADDI_X8 = 32'h00128413; // addi x8,x5,1
    localparam logic [31:0] I_A1      = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] I_A2      = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] I_A3      = 32'h00300193; // addi x3,x0,3
    localparam logic [31:0] I_A4      = 32'h00400213; // addi x4,x0,4
    localparam logic [31:0] I_JAL     = 32'h008000EF; // jal  x1,+8
    localparam logic [31:0] I_SW      = 32'hFE512E23; // sw   x5,-4(x2)
    localparam logic [31:0] I_BEQ     = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_LUI     = 32'hABCDE1B7; // lui  x3,0xABCDE
    localparam logic [31:0] I_AUIPC   = 32'h12345517; // auipc x10,0x12345
    localparam logic [31:0] I_JALR_F1 = 32'h000010E7; // jalr opcode, funct3=1
    localparam logic [31:0] I_ZERO    = 32'h00000000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    ctrl_t           out_ctrl;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [XLEN-1:0] out_imm, out_pc;

    int n_checks = 0;
    int n_fails  = 0;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_imm      (out_imm),
        .out_pc       (out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [XLEN-1:0] pc);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = pc;
    endtask

    task automatic issue(input logic [31:0] i, input logic [XLEN-1:0] pc);
        offer(i, pc);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rd", out_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // addi x5,x0,-1
        issue(I_ADDI_M1, 32'h0);
        chk("addi_valid", out_valid, 1);
        chk("addi_regwr", out_ctrl.regwr, 1);
        chk("addi_op2sel", out_ctrl.op2sel, 1);
        chk("addi_op1sel", out_ctrl.op1sel, 0);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_rd", out_rd, 5);
        step();
        chk("addi_drained", out_valid, 0);

        // Load-use: lw x6 then add x7,x6,x6
        offer(I_LW, 32'h10);
        #1;
        chk("lw_ready", in_ready, 1);
        step();
        offer(I_ADD, 32'h14);
        #1;
        chk("hz_stall", in_ready, 0);
        chk("lw_valid", out_valid, 1);
        chk("lw_memrd", out_ctrl.memrd, 1);
        chk("lw_wbsel", out_ctrl.wbsel, 1);
        chk("lw_rd", out_rd, 6);
        step();
        chk("hz_bubble", out_valid, 0);
        chk("hz_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_pc", out_pc, 32'h14);
        chk("add_rd", out_rd, 7);
        chk("add_rs1", out_rs1, 6);
        chk("add_rs2", out_rs2, 6);
        chk("add_op2sel", out_ctrl.op2sel, 0);
        step();

        // Load followed by an independent instruction: no stall
        issue(I_LW, 32'h20);
        offer(I_ADDI_X8, 32'h24);
        #1;
        chk("nohz_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("nohz_rd", out_rd, 8);
        chk("nohz_imm", out_imm, 1);
        step();

        // Stream of 4 with out_ready low for 3 cycles
        out_ready = 1'b0;
        offer(I_A1, 32'h40);
        step();
        offer(I_A2, 32'h44);
        #1;
        chk("strm_ready2", in_ready, 1);
        step();
        offer(I_A3, 32'h48);
        #1;
        chk("strm_full", in_ready, 0);
        step();
        chk("strm_hold_rd", out_rd, 1);
        chk("strm_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("strm_full_still", in_ready, 0);
        step();
        chk("strm_2nd_rd", out_rd, 2);
        chk("strm_2nd_pc", out_pc, 32'h44);
        chk("strm_ready_back", in_ready, 1);
        step();
        chk("strm_3rd_rd", out_rd, 3);
        offer(I_A4, 32'h4C);
        step();
        in_valid = 1'b0;
        chk("strm_4th_rd", out_rd, 4);
        chk("strm_4th_imm", out_imm, 4);
        step();
        chk("strm_empty", out_valid, 0);

        // Opcode classes
        issue(I_JAL, 32'h100);
        chk("jal_isjal", out_ctrl.isjal, 1);
        chk("jal_wbsel", out_ctrl.wbsel, 2);
        chk("jal_regwr", out_ctrl.regwr, 1);
        chk("jal_rd", out_rd, 1);
        chk("jal_op1sel", out_ctrl.op1sel, 1);
        chk("jal_imm", out_imm, 8);
        chk("jal_pc", out_pc, 32'h100);
        issue(I_SW, 32'h104);
        chk("sw_memwr", out_ctrl.memwr, 1);
        chk("sw_regwr", out_ctrl.regwr, 0);
        chk("sw_imm", out_imm, 32'hFFFF_FFFC);
        chk("sw_funct3", out_funct3, 2);
        issue(I_BEQ, 32'h108);
        chk("beq_isbr", out_ctrl.isbr, 1);
        chk("beq_op2sel", out_ctrl.op2sel, 0);
        chk("beq_imm", out_imm, 32'hFFFF_FFF8);
        issue(I_LUI, 32'h10C);
        chk("lui_op1sel", out_ctrl.op1sel, 2);
        chk("lui_imm", out_imm, 32'hABCD_E000);
        issue(I_AUIPC, 32'h110);
        chk("auipc_op1sel", out_ctrl.op1sel, 1);
        chk("auipc_regwr", out_ctrl.regwr, 1);
        chk("auipc_imm", out_imm, 32'h1234_5000);
        chk("auipc_rd", out_rd, 10);

        // Buffer full with a load tracked, then flush
        out_ready = 1'b0;
        issue(I_A1, 32'h200);
        offer(I_LW, 32'h204);
        step();
        in_valid = 1'b0;
        #1;
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        offer(I_ADD, 32'h208);
        #1;
        chk("fl_ready_low", in_ready, 0);
        step();
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_ready_back", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("fl_next_valid", out_valid, 1);
        chk("fl_next_rd", out_rd, 7);
        chk("fl_next_pc", out_pc, 32'h208);
        step();
        chk("fl_drained", out_valid, 0);

        // Asynchronous reset during a load-use stall
        issue(I_LW, 32'h300);
        offer(I_ADD, 32'h304);
        #1;
        chk("ar_stall", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_ctrl", out_ctrl, 0);
        chk("ar_out_pc", out_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ar_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("ar_add_rd", out_rd, 7);
        step();

        // Illegal / unknown encodings
        issue(I_ZERO, 32'h400);
        chk("zero_valid", out_valid, 1);
        chk("zero_regwr", out_ctrl.regwr, 0);
        chk("zero_memwr", out_ctrl.memwr, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("zero_illegal", out_ctrl.illegal, 1);
        issue(I_JALR_F1, 32'h404);
        chk("jalrf3_illegal", out_ctrl.illegal, 1);
        chk("jalrf3_regwr", out_ctrl.regwr, 0);
        chk("jalrf3_isjalr", out_ctrl.isjalr, 0);
`else
        chk("zero_illegal", out_ctrl.illegal, 0);
        chk("zero_ctrl", out_ctrl, 0);
        issue(I_JALR_F1, 32'h404);
        chk("jalrf3_illegal", out_ctrl.illegal, 0);
        chk("jalrf3_regwr", out_ctrl.regwr, 1);
        chk("jalrf3_isjalr", out_ctrl.isjalr, 1);
        chk("jalrf3_wbsel", out_ctrl.wbsel, 2);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
